// File: rtl/sample_scheduler.sv
// Sample-rate frame scheduler for a MAC filter datapath.
// A period counter issues ticks; each tick runs one capture/clear/MAC/sat/out frame.
module sample_scheduler #(
  parameter int DIV_W = 16,
  parameter int TAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic [TAP_W-1:0] n_taps,
  input  logic             adc_ready,
  input  logic             ovr_clr,
  output logic             EN_in,
  output logic             acc_clr,
  output logic             EN_mac,
  output logic [TAP_W-1:0] tap_idx,
  output logic             EN_sat,
  output logic             EN_out,
  output logic             busy,
  output logic             overrun
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CAPTURE = 3'd1;
  localparam logic [2:0] CLEAR   = 3'd2;
  localparam logic [2:0] MAC     = 3'd3;
  localparam logic [2:0] SAT     = 3'd4;
  localparam logic [2:0] OUT     = 3'd5;

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic [DIV_W-1:0] cnt;
  logic [TAP_W-1:0] taps;
  logic             tick;
  logic             idle;
  logic             last_tap;

  assign tick     = run && (cnt >= div);
  assign idle     = (state == IDLE);
  assign last_tap = (tap_idx == taps);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (tick) nxt = CAPTURE;
      CAPTURE: if (adc_ready) nxt = CLEAR;
      CLEAR:   nxt = MAC;
      MAC:     if (last_tap) nxt = SAT;
      SAT:     nxt = OUT;
      OUT:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Tap count is frozen for the frame so live edits only affect later frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps <= '0;
    end else if (idle && tick) begin
      taps <= n_taps;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_idx <= '0;
    end else if (state == MAC && !last_tap) begin
      tap_idx <= tap_idx + TAP_W'(1);
    end else begin
      tap_idx <= '0;
    end
  end

  // A colliding tick outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (tick && !idle) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  assign EN_in   = (state == CAPTURE);
  assign acc_clr = (state == CLEAR);
  assign EN_mac  = (state == MAC);
  assign EN_sat  = (state == SAT);
  assign EN_out  = (state == OUT);
  assign busy    = !idle;

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: a frame-timeline model pushes per-cycle
// expected outputs into a scoreboard queue that each test pops and compares.
module tb_sample_scheduler;

  localparam int DIV_W = 16;
  localparam int TAP_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic [DIV_W-1:0] div = 16'd9;
  logic [TAP_W-1:0] n_taps = 3'd2;
  logic             adc_ready = 1'b1;
  logic             ovr_clr = 1'b0;
  logic             EN_in;
  logic             acc_clr;
  logic             EN_mac;
  logic [TAP_W-1:0] tap_idx;
  logic             EN_sat;
  logic             EN_out;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sample_scheduler #(.DIV_W(DIV_W), .TAP_W(TAP_W)) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .div(div),
    .n_taps(n_taps),
    .adc_ready(adc_ready),
    .ovr_clr(ovr_clr),
    .EN_in(EN_in),
    .acc_clr(acc_clr),
    .EN_mac(EN_mac),
    .tap_idx(tap_idx),
    .EN_sat(EN_sat),
    .EN_out(EN_out),
    .busy(busy),
    .overrun(overrun)
  );

  // bits: 9 in, 8 clr, 7 mac, 6:4 idx, 3 sat, 2 out, 1 busy, 0 ovr
  function automatic logic [9:0] obs();
    return {EN_in, acc_clr, EN_mac, tap_idx, EN_sat, EN_out, busy, overrun};
  endfunction

  logic [7:0]       sched[$];
  logic [9:0]       exp_q[$];
  logic [DIV_W-1:0] m_cnt = '0;
  logic             m_ovr = 1'b0;

  // Frame timeline: a tick while no frame is pending schedules a full frame.
  always @(posedge clk or negedge rst) begin : model
    logic tk;
    logic act;
    logic hold;
    logic novr;
    if (!rst) begin
      sched.delete();
      m_cnt <= '0;
      m_ovr <= 1'b0;
    end else begin
      tk = run && (m_cnt >= div);
      act = (sched.size() != 0);
      hold = act && sched[0][7] && !adc_ready;
      if (act && !hold) void'(sched.pop_front());
      if (tk && !act) begin
        sched.push_back(8'b1000_0000);
        sched.push_back(8'b0100_0000);
        for (int i = 0; i <= int'(n_taps); i++)
          sched.push_back({3'b001, TAP_W'(i), 2'b00});
        sched.push_back(8'b0000_0010);
        sched.push_back(8'b0000_0001);
      end
      novr = m_ovr;
      if (tk && act) novr = 1'b1;
      else if (ovr_clr) novr = 1'b0;
      m_ovr <= novr;
      m_cnt <= (!run || tk) ? '0 : m_cnt + DIV_W'(1);
      if (sched.size() != 0) exp_q.push_back({sched[0], 1'b1, novr});
      else exp_q.push_back({8'h00, 1'b0, novr});
    end
  end

  task automatic cyc(output logic [9:0] e, output logic [9:0] o);
    @(negedge clk);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
    o = obs();
  endtask

  task automatic test_reset();
    logic [9:0] e, o;
    int first;
    rst = 1'b0; run = 1'b1; div = 16'd9; n_taps = 3'd2; adc_ready = 1'b1;
    repeat (3) @(negedge clk);
    o = obs();
    checks++;
    if (o !== 10'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected %h", o, 10'd0);
    end
    exp_q.delete();
    rst = 1'b1;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL reset_sb: got %h expected %h", o, e);
      end
      if (first == 0 && o[9]) first = k;
    end
    checks++;
    if (first != int'(div) + 1) begin
      fails++; $display("FAIL first_tick: got %0d expected %0d", first, int'(div) + 1);
    end
  endtask

  task automatic test_frame();
    logic [9:0] e, o;
    int c_in, c_clr, c_mac, c_sat, c_out, seen;
    c_in = 0; c_clr = 0; c_mac = 0; c_sat = 0; c_out = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL frame_sb: got %h expected %h", o, e);
      end
      checks++;
      if ($countones({o[9:7], o[3:2]}) > 1) begin
        fails++; $display("FAIL onehot: got %h expected at most one enable", o);
      end
      c_in += int'(o[9]); c_clr += int'(o[8]); c_mac += int'(o[7]);
      c_sat += int'(o[3]); c_out += int'(o[2]);
    end
    checks++;
    if (c_in != 3 || c_clr != 3 || c_mac != 9 || c_sat != 3 || c_out != 3) begin
      fails++;
      $display("FAIL frame_counts: got %0d/%0d/%0d/%0d/%0d expected 3/3/9/3/3",
               c_in, c_clr, c_mac, c_sat, c_out);
    end
    checks++;
    if (o[0] !== 1'b0) begin
      fails++; $display("FAIL frame_no_ovr: got %b expected 0", o[0]);
    end
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL frame_sb: got %h expected %h", o, e);
      end
      if (o[2]) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      fails++; $display("FAIL frame_wait_out: got timeout expected EN_out");
    end
    div = 16'd7;
    c_in = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL min_div_sb: got %h expected %h", o, e);
      end
      c_in += int'(o[9]);
    end
    checks++;
    if (c_in != 5 || o[0] !== 1'b0) begin
      fails++; $display("FAIL min_div: got %0d frames ovr %b expected 5 frames ovr 0", c_in, o[0]);
    end
  endtask

  task automatic test_overrun();
    logic [9:0] e, o;
    int seen, hi, c_in;
    div = 16'd6; n_taps = 3'd2;
    for (int k = 0; k < 40; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL ovr_sb: got %h expected %h", o, e);
      end
    end
    checks++;
    if (o[0] !== 1'b1) begin
      fails++; $display("FAIL ovr_set: got %b expected 1", o[0]);
    end
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL ovr_sb: got %h expected %h", o, e);
      end
      if (o[9]) seen = 1;
    end
    ovr_clr = 1'b1;
    cyc(e, o);
    ovr_clr = 1'b0;
    checks++;
    if (o[0] !== 1'b0 || seen == 0) begin
      fails++; $display("FAIL ovr_clr: got %b expected 0", o[0]);
    end
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL ovr_sb: got %h expected %h", o, e);
      end
      if (o[0]) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      fails++; $display("FAIL ovr_reset_again: got timeout expected overrun 1");
    end
    ovr_clr = 1'b1;
    cyc(e, o);
    hi = 0;
    for (int k = 0; k < 21; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL ovr_win_sb: got %h expected %h", o, e);
      end
      hi += int'(o[0]);
    end
    ovr_clr = 1'b0;
    checks++;
    if (hi == 0) begin
      fails++; $display("FAIL ovr_set_wins: got %0d set cycles expected >0", hi);
    end
    c_in = 0;
    for (int k = 0; k < 28; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL ovr_sb: got %h expected %h", o, e);
      end
      c_in += int'(o[9]);
    end
    checks++;
    if (c_in != 2) begin
      fails++; $display("FAIL ovr_drop: got %0d frames expected 2", c_in);
    end
  endtask

  task automatic test_capture_stall();
    logic [9:0] e, o;
    int seen, cin, kin, kout, macs;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL stall_sb: got %h expected %h", o, e);
      end
      if (o[2]) seen = 1;
    end
    div = 16'd20; adc_ready = 1'b0; ovr_clr = 1'b1;
    cyc(e, o);
    ovr_clr = 1'b0;
    cin = 0; kin = 0; kout = 0; macs = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL stall_sb: got %h expected %h", o, e);
      end
      if (kout == 0) begin
        if (o[9]) begin
          cin++;
          if (kin == 0) kin = k;
          if (cin == 5) adc_ready = 1'b1;
        end
        if (kin != 0 && o[7]) macs++;
        if (kin != 0 && o[2]) kout = k;
      end
    end
    adc_ready = 1'b1;
    checks++;
    if (cin != 5 || macs != 3) begin
      fails++; $display("FAIL stall_len: got in %0d mac %0d expected in 5 mac 3", cin, macs);
    end
    checks++;
    if (kout - kin != 10) begin
      fails++; $display("FAIL stall_shift: got %0d expected 10", kout - kin);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e, o;
    int seen, first;
    div = 16'd9; n_taps = 3'd2; adc_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL rstmid_sb: got %h expected %h", o, e);
      end
      if (o[7] && o[6:4] == 3'd1) seen = 1;
    end
    #2 rst = 1'b0;
    #1 o = obs();
    checks++;
    if (o !== 10'd0 || seen == 0) begin
      fails++; $display("FAIL rstmid_async: got %h expected %h", o, 10'd0);
    end
    exp_q.delete();
    @(negedge clk);
    o = obs();
    checks++;
    if (o !== 10'd0) begin
      fails++; $display("FAIL rstmid_hold: got %h expected %h", o, 10'd0);
    end
    rst = 1'b1;
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL rstmid_sb: got %h expected %h", o, e);
      end
      if (first == 0 && o[9]) first = k;
    end
    checks++;
    if (first != 10) begin
      fails++; $display("FAIL rstmid_restart: got %0d expected 10", first);
    end
  endtask

  task automatic test_run_drop();
    logic [9:0] e, o;
    int seen, macs, c_in, c_sat;
    div = 16'd12; n_taps = 3'd4;
    seen = 0;
    for (int k = 0; k < 60 && seen < 2; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL drop_sb: got %h expected %h", o, e);
      end
      if (seen == 0 && o[9]) seen = 1;
      if (seen == 1 && o[7]) seen = 2;
    end
    n_taps = 3'd1; run = 1'b0;
    macs = (seen == 2) ? 1 : 0;
    c_in = 0; c_sat = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(e, o);
      checks++;
      if (o !== e) begin
        fails++; $display("FAIL drop_sb: got %h expected %h", o, e);
      end
      macs += int'(o[7]); c_in += int'(o[9]); c_sat += int'(o[3]);
    end
    checks++;
    if (macs != 5 || c_sat != 1) begin
      fails++; $display("FAIL drop_latched: got mac %0d sat %0d expected mac 5 sat 1", macs, c_sat);
    end
    checks++;
    if (c_in != 0 || o[1] !== 1'b0) begin
      fails++; $display("FAIL drop_stop: got in %0d busy %b expected in 0 busy 0", c_in, o[1]);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_capture_stall();
    test_reset_mid();
    test_run_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, width of the sample-period divider.
REQ-002 The block SHALL have parameter TAP_W, default 3, width of the tap count and tap index (up to 2^TAP_W MAC steps).
REQ-003 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port run  input  1  system enable; while high, the sample-period counter runs.
REQ-006 The block SHALL have port div  input  DIV_W  sample period in clocks minus 1.
REQ-007 The block SHALL have port n_taps  input  TAP_W  number of MAC steps minus 1.
REQ-008 The block SHALL have port adc_ready  input  1  datapath input sample valid; completes capture.
REQ-009 The block SHALL have port ovr_clr  input  1  clears the sticky overrun flag.
REQ-010 The block SHALL have port EN_in  output  1  input-register load enable.
REQ-011 The block SHALL have port acc_clr  output  1  accumulator clear.
REQ-012 The block SHALL have port EN_mac  output  1  multiply-accumulate enable.
REQ-013 The block SHALL have port tap_idx  output  TAP_W  coefficient/sample index of the current MAC step.
REQ-014 The block SHALL have port EN_sat  output  1  saturation/rounding stage enable.
REQ-015 The block SHALL have port EN_out  output  1  output-register load enable.
REQ-016 The block SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-017 The block SHALL have port overrun  output  1  sticky flag: sample tick arrived while a frame was in progress.

Function
REQ-018 The period counter SHALL count from 0 while run=1, produce an internal tick in the cycle where cnt >= div, and return to 0 on the next edge; a live change of div SHALL take effect immediately.
REQ-019 While run=0, the counter SHALL be held at 0, no tick SHALL be produced, and any frame in progress SHALL run to completion.
REQ-020 The FSM SHALL have the states IDLE, CAPTURE, CLEAR, MAC, SAT and OUT, with all enables decoded as Moore outputs of the current state.
REQ-021 IDLE -> CAPTURE on tick; n_taps SHALL be latched at this edge and used for the whole frame.
REQ-022 In CAPTURE, EN_in=1; CAPTURE -> CLEAR on the first edge where adc_ready=1; otherwise the FSM SHALL stay in CAPTURE indefinitely.
REQ-023 In CLEAR, acc_clr=1 for exactly 1 cycle, then CLEAR -> MAC.
REQ-024 In MAC, EN_mac=1 and tap_idx SHALL step 0,1,...,n_taps_latched, one per cycle; MAC -> SAT after the cycle with tap_idx=n_taps_latched; tap_idx SHALL be 0 outside MAC.
REQ-025 SAT (EN_sat=1) and OUT (EN_out=1) SHALL each last 1 cycle; SAT -> OUT -> IDLE.
REQ-026 With adc_ready held high, a tick at cycle t SHALL give CAPTURE at t+1, CLEAR at t+2, MAC at t+3..t+3+n, SAT at t+n+4, OUT at t+n+5 and IDLE at t+n+6.
REQ-027 At most one enable among EN_in, acc_clr, EN_mac, EN_sat and EN_out SHALL be high in any cycle.
REQ-028 A tick in any non-IDLE state SHALL be dropped (no frame queued) and SHALL set overrun on the next edge.
REQ-029 ovr_clr=1 SHALL clear overrun on the next edge; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-030 With adc_ready always high, overrun-free operation SHALL require div >= n_taps+5; div = n_taps+4 SHALL overrun on every frame.

Reset
REQ-031 rst=0 SHALL asynchronously force state=IDLE, cnt=0, tap_idx=0, latched n_taps=0 and overrun=0, with every output 0; this SHALL hold mid-frame, and the first tick SHALL occur div+1 cycles after run is high with rst=1.

Verification
REQ-032 div=9, n_taps=2, adc_ready=1, run=1 -> frame every 10 cycles; EN_in 1 cycle, acc_clr 1, EN_mac 3 cycles with tap_idx 0,1,2, EN_sat 1, EN_out 1; overrun stays 0.
REQ-033 div=6, n_taps=2 -> overrun=1 after the first frame's OUT-cycle tick, every second tick is dropped; ovr_clr pulse -> 0, and it is set again on the next colliding tick.
REQ-034 adc_ready held low 4 cycles after CAPTURE is entered -> EN_in high 5 cycles, and the later phases shift by 4 cycles.
REQ-035 rst pulsed low during MAC at tap_idx=1 -> all outputs 0 immediately; after release with run=1, a clean frame starts at the next tick.
REQ-036 run dropped during MAC -> the frame completes through OUT, then no further EN_in occurs; n_taps changed mid-frame -> the current frame still uses the latched value.
